// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   sub_state_t : controller state encoding (IDLE, RUN, DONE)
//   cnt_width() : bit-counter width for a given operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_full_sub_if.sv
// Controller-facing handshake and operand/result bus of the serial subtractor.
//   master : controller side (drives start, a, b; observes busy, done, diff, borrow_out)
//   slave  : subtractor side
interface serial_full_sub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/full_sub_mux.sv
// Mux-based one-bit full subtractor cell: ai - bi - bin.
//   ai, bi : operand bits
//   bin    : borrow in
//   d      : difference bit
//   bo     : borrow out
module full_sub_mux (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bo
);

    // Operand pair selects either the borrow or its complement.
    always_comb begin
        d  = bin;
        bo = bin;
        case ({ai, bi})
            2'b00: begin d = bin;  bo = bin;  end
            2'b01: begin d = ~bin; bo = 1'b1; end
            2'b10: begin d = ~bin; bo = 1'b0; end
            2'b11: begin d = bin;  bo = bin;  end
            default: begin d = bin; bo = bin; end
        endcase
    end

endmodule

// File: rtl/serial_full_sub.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of serial_full_sub_if (start/a/b in; busy/done/diff/borrow_out out)
module serial_full_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_full_sub_if.slave  bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    sub_state_t       state;
    sub_state_t       state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;

    full_sub_mux u_cell (
        .ai  (a_sr[0]),
        .bi  (b_sr[0]),
        .bin (borrow),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // New difference bit enters at the MSB while the register shifts right.
    assign res_next = (res_sr >> 1) | {cell_d, {(WIDTH-1){1'b0}}};

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; busy/done registered from the next state so they track it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next == RUN);
            done_q <= (state_next == DONE);
        end
    end

    // Operand shifters, borrow flop, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr         <= '0;
            b_sr         <= '0;
            res_sr       <= '0;
            cnt          <= '0;
            borrow       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        res_sr <= '0;
                        cnt    <= '0;
                        borrow <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    borrow <= cell_bo;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        diff_q       <= res_next;
                        borrow_out_q <= cell_bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_full_sub.sv
// Self-checking bench for serial_full_sub (WIDTH = 8): cell truth table,
// directed vector table, start-ignore, mid-run reset and random operands.
module tb_serial_full_sub;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_diff;
        logic         exp_bo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic c_ai, c_bi, c_bin, c_d, c_bo;

    serial_full_sub_if #(.WIDTH(W)) bus ();

    serial_full_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    full_sub_mux u_cell_chk (
        .ai  (c_ai),
        .bi  (c_bi),
        .bin (c_bin),
        .d   (c_d),
        .bo  (c_bo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One full operation from a single start pulse; checks latency, busy span and result.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_diff, input logic exp_bo);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~a; bus.b = ~b;
        cycles = 1;
        busy_cnt = 0;
        while (!bus.done && cycles < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check({name, " latency"}, 32'(cycles - 1), W);
        check({name, " busy_cycles"}, 32'(busy_cnt), W);
        check({name, " busy_at_done"}, 32'(bus.busy), 0);
        check({name, " diff"}, 32'(bus.diff), 32'(exp_diff));
        check({name, " borrow_out"}, 32'(bus.borrow_out), 32'(exp_bo));
        @(negedge clk);
        check({name, " done_pulse"}, 32'(bus.done), 0);
    endtask

    vec_t vt[6];

    initial begin
        int cycles;
        logic [W-1:0] ra, rb;
        logic [W:0]   wide;

        vt[0] = '{a: 8'd200, b: 8'd55,  exp_diff: 8'd145, exp_bo: 1'b0};
        vt[1] = '{a: 8'd5,   b: 8'd10,  exp_diff: 8'd251, exp_bo: 1'b1};
        vt[2] = '{a: 8'd0,   b: 8'd255, exp_diff: 8'd1,   exp_bo: 1'b1};
        vt[3] = '{a: 8'd0,   b: 8'd0,   exp_diff: 8'd0,   exp_bo: 1'b0};
        vt[4] = '{a: 8'd255, b: 8'd1,   exp_diff: 8'd254, exp_bo: 1'b0};
        vt[5] = '{a: 8'd77,  b: 8'd77,  exp_diff: 8'd0,   exp_bo: 1'b0};

        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        c_ai = 1'b0; c_bi = 1'b0; c_bin = 1'b0;

        // Cell truth table against arithmetic definition.
        for (int i = 0; i < 8; i++) begin
            {c_ai, c_bi, c_bin} = 3'(i);
            #1;
            check($sformatf("cell_d[%0d]", i), 32'(c_d), 32'(c_ai ^ c_bi ^ c_bin));
            check($sformatf("cell_bo[%0d]", i), 32'(c_bo),
                  32'(((2'(c_bi) + 2'(c_bin)) > 2'(c_ai)) ? 1 : 0));
        end

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst busy", 32'(bus.busy), 0);
        check("rst done", 32'(bus.done), 0);
        check("rst diff", 32'(bus.diff), 0);
        check("rst borrow_out", 32'(bus.borrow_out), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].exp_diff, vt[i].exp_bo);

        // start with new operands during RUN and DONE is ignored; held start re-accepts after DONE.
        @(negedge clk);
        bus.a = 8'd200; bus.b = 8'd55; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.a = 8'd9; bus.b = 8'd3; bus.start = 1'b1;
        cycles = 4;
        while (!bus.done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check("ign latency", 32'(cycles - 1), W);
        check("ign diff", 32'(bus.diff), 145);
        check("ign borrow_out", 32'(bus.borrow_out), 0);
        @(negedge clk);
        check("ign idle done", 32'(bus.done), 0);
        check("ign idle busy", 32'(bus.busy), 0);
        @(negedge clk);
        check("ign reaccept busy", 32'(bus.busy), 1);
        cycles = 1;
        while (!bus.done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        check("held latency", 32'(cycles - 1), W);
        check("held diff", 32'(bus.diff), 6);
        check("held borrow_out", 32'(bus.borrow_out), 0);
        @(negedge clk);

        // Reset during the 4th RUN cycle aborts and clears outputs.
        @(negedge clk);
        bus.a = 8'd3; bus.b = 8'd200; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst busy", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst busy", 32'(bus.busy), 0);
        check("mid_rst done", 32'(bus.done), 0);
        check("mid_rst diff", 32'(bus.diff), 0);
        check("mid_rst borrow_out", 32'(bus.borrow_out), 0);
        do_op("post_rst", 8'd100, 8'd1, 8'd99, 1'b0);

        // Random operands against plain arithmetic.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            wide = {1'b0, ra} - {1'b0, rb};
            do_op($sformatf("rnd%0d", i), ra, rb, wide[W-1:0], (ra < rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
